tcdm_bank_ctrl: RTL and testbench
=================================

Name: tcdm_bank_ctrl

Overview:
- Slave-side bank controller placed directly downstream of one crossbar slave port.
- Accepts req/gnt requests, drives a single-port SRAM macro with 1-cycle read latency, and returns one in-order response per granted request over an r_valid/r_ready channel.
- Buffers responses in a credit-guarded FIFO, so the xbar can apply r_ready backpressure without losing data.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, request address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- SRAM_ADDR_WIDTH, 10, SRAM word-address width.
- ADDR_LSB, 2, lowest address bit used for the word index (skips byte and bank-select bits).
- RSP_DEPTH, 4, response FIFO depth and maximum outstanding requests; must be >= 1. Full throughput requires >= 3.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- addr_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1 = write, 0 = read
- be_i  in  BE_WIDTH  write byte enables
- data_i  in  DATA_WIDTH  write data
- r_data_o  out  DATA_WIDTH  response data
- r_valid_o  out  1  response valid
- r_ready_i  in  1  response accepted
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  SRAM_ADDR_WIDTH  SRAM word address
- sram_be_o  out  BE_WIDTH  SRAM byte enables
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: gnt_o=0, r_valid_o=0, r_data_o=0, sram_req_o=0. The outstanding counter, FIFO pointers, FIFO count and in-flight flag all clear to 0.
- Reset mid-operation: all pending responses are dropped. Nothing is emitted after reset releases.
- Outstanding counter cnt (0..RSP_DEPTH):
  - +1 on grant.
  - -1 on response handshake (r_valid_o & r_ready_i).
  - Both in the same cycle: unchanged.
- Grant rule: gnt_o = req_i & (cnt < RSP_DEPTH). This is combinational from req_i and registered cnt. A same-cycle pop does not free a credit.
- SRAM drive: on grant, in the same cycle:
  - sram_req_o=1, sram_we_o=wen_i
  - sram_addr_o=addr_i[ADDR_LSB+SRAM_ADDR_WIDTH-1:ADDR_LSB]
  - sram_be_o=be_i (read: all ones), sram_wdata_o=data_i
- SRAM drive with no grant: sram_req_o=0 and the other SRAM outputs are don't-care.
- In-flight stage: registered one cycle after grant, capturing wen.
  - Next cycle, a FIFO entry is pushed: data = sram_rdata_i for a read, 0 for a write.
  - Every granted request, read or write, yields exactly one response.
- Latency: r_valid_o rises 2 cycles after the grant cycle when the FIFO was empty. Responses leave strictly in grant order.
- FIFO:
  - Registered head drives r_data_o; r_valid_o = (fifo_cnt != 0).
  - Head is held stable while r_valid_o & !r_ready_i.
  - Push and pop in the same cycle are both allowed, including when full or when fifo_cnt=1.
  - Pointers wrap modulo RSP_DEPTH.
  - The credit rule guarantees a push never overflows. Overflow is asserted as a never-event in simulation.
- Addresses: bits outside the index slice are ignored. be_i is ignored for reads.
- Throughput: with RSP_DEPTH>=3 and r_ready_i=1, one grant per cycle is sustained.

Test Plan:
- Reset, then a single read of addr 0x0000_0010 with the SRAM model holding 0xDEAD_BEEF at word 4 -> gnt_o in cycle 0; sram_addr_o=4, sram_we_o=0; r_valid_o=1 with r_data_o=0xDEAD_BEEF in cycle 2.
- Write 0x1234_5678 with be=4'b0011 to addr 0x20, then read back -> sram_we_o=1, sram_be_o=0011 on the write; write response r_data_o=0; read returns 0x0000_5678 (SRAM init 0); responses come back in order.
- r_ready_i=0 with req_i held high, RSP_DEPTH=4 -> exactly 4 grants, then gnt_o=0. r_data_o stays stable. Raising r_ready_i drains 4 responses in order, and gnt_o reasserts the cycle after the first pop.
- Back-to-back reads of words 0..15 with r_ready_i=1 -> 16 consecutive grants, 16 consecutive responses starting 2 cycles later, data matching in order, FIFO wrap exercised.
- Random r_ready_i (50%) with random read/write traffic for 2000 requests -> scoreboard shows no lost, duplicated or reordered responses, and cnt never exceeds RSP_DEPTH.
- Assert rst_i with 3 responses pending -> r_valid_o and gnt_o go to 0 immediately (asynchronous). After release, no stale responses appear, and a new read completes with 2-cycle latency.

Source files
------------

// File: rtl/tcdm_bank_ctrl.sv
// TCDM bank controller: req/gnt front end, single-port SRAM with 1-cycle read
// latency, and an in-order response FIFO guarded by an outstanding-request credit.
module tcdm_bank_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH/8,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int ADDR_LSB        = 2,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  output logic                       gnt_o,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic                       wen_i,
  input  logic [BE_WIDTH-1:0]        be_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  output logic [DATA_WIDTH-1:0]      r_data_o,
  output logic                       r_valid_o,
  input  logic                       r_ready_i,
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [BE_WIDTH-1:0]        sram_be_o,
  output logic [DATA_WIDTH-1:0]      sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_i
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

  logic [CW-1:0]         cnt, fifo_cnt;
  logic [PW-1:0]         wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic                  inflight, inflight_we;
  logic                  push, pop;
  logic                  unused_addr;

  assign unused_addr = ^addr_i;

  // Credit counts every granted request not yet handed back, so the FIFO can
  // never be asked to hold more than RSP_DEPTH entries.
  assign gnt_o = req_i & ~rst_i & (cnt < DEPTH_C);

  assign sram_req_o   = gnt_o;
  assign sram_we_o    = wen_i;
  assign sram_addr_o  = addr_i[ADDR_LSB +: SRAM_ADDR_WIDTH];
  assign sram_be_o    = wen_i ? be_i : '1;
  assign sram_wdata_o = data_i;

  assign push      = inflight;
  assign r_valid_o = (fifo_cnt != '0);
  assign pop       = r_valid_o & r_ready_i;
  assign r_data_o  = mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
    end else begin
      inflight    <= gnt_o;
      inflight_we <= wen_i;
      if (gnt_o && !pop)      cnt <= cnt + 1'b1;
      else if (!gnt_o && pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      // Writes still produce a response so the xbar sees one reply per grant.
      if (push) begin
        mem[wptr] <= inflight_we ? '0 : sram_rdata_i;
        wptr      <= (wptr == LAST_P) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == LAST_P) ? '0 : rptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_cnt == DEPTH_C));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt <= DEPTH_C);

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Bench for tcdm_bank_ctrl: SRAM model, queue-based response model checked
// every cycle, directed literal checks and randomized traffic.
module tb_tcdm_bank_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, gnt, wen = 1'b0, r_valid, r_ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0, r_data, sram_wdata, sram_rdata;
  logic [3:0]  be = '0, sram_be;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;

  int n_cmp = 0, n_err = 0, cyc = 0;

  tcdm_bank_ctrl #(.RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .wen_i(wen), .be_i(be), .data_i(wdata), .r_data_o(r_data),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .sram_req_o(sram_req),
    .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_be_o(sram_be),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model (environment) and the reference memory image (model)
  logic [31:0] smem [1024];
  logic [31:0] gold [1024];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 32'hA500_0000 | 32'(i);
      gold[i] = 32'hA500_0000 | 32'(i);
    end
    smem[4] = 32'hDEAD_BEEF; gold[4] = 32'hDEAD_BEEF;
    smem[8] = 32'h0;         gold[8] = 32'h0;
  end

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) smem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= smem[sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a queue of expected responses, each visible from 2 cycles after grant
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t q[$];

  always @(negedge clk) begin
    logic exp_gnt, exp_v;
    logic [31:0] d;
    logic [9:0] idx;
    cyc++;
    if (rst) begin
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(r_valid), 0);
      chk("rst_rdata", r_data, 0);
      chk("rst_sreq", 32'(sram_req), 0);
      q.delete();
    end else begin
      exp_gnt = req && (q.size() < DEPTH);
      exp_v   = (q.size() > 0) && (q[0].due <= cyc);
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("sram_req", 32'(sram_req), 32'(exp_gnt));
      chk("r_valid", 32'(r_valid), 32'(exp_v));
      if (exp_v) chk("r_data", r_data, q[0].data);
      if (exp_gnt) begin
        idx = addr[11:2];
        chk("sram_addr", 32'(sram_addr), 32'(idx));
        chk("sram_we", 32'(sram_we), 32'(wen));
        chk("sram_be", 32'(sram_be), wen ? 32'(be) : 32'hF);
        chk("sram_wdata", sram_wdata, wdata);
        if (wen) begin
          for (int b = 0; b < 4; b++) if (be[b]) gold[idx][8*b +: 8] = wdata[8*b +: 8];
          d = '0;
        end else d = gold[idx];
        q.push_back('{due: cyc + 2, data: d});
      end
      if (exp_v && r_ready) void'(q.pop_front());
    end
  end

  task automatic drive(input logic rq, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d, input logic rdy);
    @(posedge clk); #1;
    req = rq; addr = a; wen = w; be = b; wdata = d; r_ready = rdy;
  endtask

  initial begin
    int g, k;
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_rvalid", 32'(r_valid), 0);
    @(posedge clk); #1 rst = 1'b0;

    // single read of word 4
    drive(1, 32'h10, 0, 4'h0, 0, 1); @(negedge clk);
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_addr", 32'(sram_addr), 4);
    chk("t1_we", 32'(sram_we), 0);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t1_lat1", 32'(r_valid), 0);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t1_valid", 32'(r_valid), 1);
    chk("t1_data", r_data, 32'hDEAD_BEEF);

    // partial write then read back
    drive(1, 32'h20, 1, 4'b0011, 32'h1234_5678, 1); @(negedge clk);
    chk("t2_we", 32'(sram_we), 1);
    chk("t2_be", 32'(sram_be), 32'h3);
    drive(1, 32'h20, 0, 4'h0, 0, 1);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t2_wr_rsp", r_data, 0);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t2_rd_rsp", r_data, 32'h0000_5678);
    repeat (2) drive(0, 0, 0, 0, 0, 1);

    // backpressure: exactly DEPTH grants, head held stable
    g = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'(i * 4), 0, 4'h0, 0, 0); @(negedge clk);
      if (gnt) g++;
      if (i >= 2) chk("t3_hold", r_data, 32'hA500_0000);
    end
    chk("t3_grants", 32'(g), 4);
    drive(1, 32'h40, 0, 4'h0, 0, 1); @(negedge clk);
    chk("t3_pop_nogrant", 32'(gnt), 0);
    drive(1, 32'h40, 0, 4'h0, 0, 1); @(negedge clk);
    chk("t3_regrant", 32'(gnt), 1);
    chk("t3_second", r_data, 32'hA500_0001);
    repeat (8) drive(0, 0, 0, 0, 0, 1);

    // back-to-back reads of words 0..15
    g = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'(i * 4), 0, 4'h0, 0, 1); @(negedge clk);
      if (gnt) g++;
      if (i == 2) chk("t4_first", r_data, 32'hA500_0000);
    end
    chk("t4_grants", 32'(g), 16);
    repeat (4) drive(0, 0, 0, 0, 0, 1);

    // random traffic with 50% backpressure
    g = 0; k = 0;
    while (g < 2000 && k < 20000) begin
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 4'($urandom),
            $urandom, 1'($urandom));
      @(negedge clk);
      if (gnt) g++;
      k++;
    end
    chk("t5_grants", 32'(g), 2000);
    repeat (10) drive(0, 0, 0, 0, 0, 1);

    // known word for the post-reset read
    drive(1, 32'h30, 1, 4'hF, 32'hCAFE_F00D, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 1);

    // reset with 3 responses pending
    for (int i = 0; i < 3; i++) drive(1, 32'(i * 4), 0, 4'h0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_pending", 32'(r_valid), 1);
    @(posedge clk); #1 req = 1'b1; rst = 1'b1;
    #1;
    chk("t6_async_rvalid", 32'(r_valid), 0);
    chk("t6_async_gnt", 32'(gnt), 0);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1); @(negedge clk);
      chk("t6_no_stale", 32'(r_valid), 0);
    end
    drive(1, 32'h30, 0, 4'h0, 0, 1); @(negedge clk);
    chk("t6_gnt", 32'(gnt), 1);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t6_lat1", 32'(r_valid), 0);
    drive(0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("t6_valid", 32'(r_valid), 1);
    chk("t6_data", r_data, 32'hCAFE_F00D);
    repeat (2) drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
